// File: rtl/prio_scan_encoder.sv
// prio_scan_encoder
//   Sequential priority encoder. Captures an N-bit request word and presents
//   the index of every set bit, one per out_valid/out_ready handshake, in
//   priority order (MSB_FIRST=1: highest index first, 0: lowest first).
//   Each accepted index is cleared from the pending word. A new word is only
//   accepted once the current word is fully drained.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   data_in      request word, sampled when load & load_ready
//   load         capture request
//   load_ready   pending word is empty, a new word can be captured
//   code         index of the current priority bit (0 when idle)
//   out_valid    code is meaningful
//   out_ready    consumer accepts code this cycle
//   last         current code is the final pending bit
//   pending_cnt  number of bits still pending (0..N)
//   zero_load    one-cycle pulse after an all-zero word was captured
module prio_scan_encoder #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  data_in,
    input  logic          load,
    output logic          load_ready,
    output logic [CW-1:0] code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          last,
    output logic [CW:0]   pending_cnt,
    output logic          zero_load
);

    logic [N-1:0]  r_pending;
    logic          r_zero_load;

    logic [CW-1:0] w_code;
    logic [CW:0]   w_cnt;
    logic [N-1:0]  w_sel;
    logic          w_accept_load;
    logic          w_handshake;

    // Priority pick: the last assignment in loop order wins, so the scan
    // direction is chosen to end on the priority bit.
    always_comb begin
        w_code = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++)
                if (r_pending[i]) w_code = CW'(i);
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (r_pending[i]) w_code = CW'(i);
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N; i++)
            w_cnt = w_cnt + {{CW{1'b0}}, r_pending[i]};
    end

    // One-hot of the bit being serviced; cleared on handshake.
    always_comb begin
        w_sel = '0;
        w_sel[w_code] = 1'b1;
    end

    assign load_ready    = (r_pending == '0);
    assign out_valid     = ~load_ready;
    assign code          = w_code;
    assign pending_cnt   = w_cnt;
    // Exactly one bit set: non-empty and clearing the lowest set bit empties it.
    assign last          = out_valid &
                           ((r_pending & (r_pending - {{(N-1){1'b0}}, 1'b1})) == '0);
    assign zero_load     = r_zero_load;

    assign w_accept_load = load & load_ready;
    assign w_handshake   = out_valid & out_ready;

    // load_ready and out_valid are mutually exclusive, so load and
    // handshake never compete for r_pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_zero_load <= 1'b0;
        end else begin
            r_zero_load <= w_accept_load & (data_in == '0);
            if (w_accept_load)
                r_pending <= data_in;
            else if (w_handshake)
                r_pending <= r_pending & ~w_sel;
        end
    end

endmodule

// File: tb/tb_prio_scan_encoder.sv
module tb_prio_scan_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A: N=8, MSB first
    logic [7:0] a_din = '0;
    logic       a_ld = 0, a_ordy = 0;
    logic       a_lr, a_ov, a_last, a_zl;
    logic [2:0] a_code;
    logic [3:0] a_cnt;

    // DUT B: N=8, LSB first
    logic [7:0] b_din = '0;
    logic       b_ld = 0, b_ordy = 0;
    logic       b_lr, b_ov, b_last, b_zl;
    logic [2:0] b_code;
    logic [3:0] b_cnt;

    // DUT C: N=16, MSB first
    logic [15:0] c_din = '0;
    logic        c_ld = 0, c_ordy = 0;
    logic        c_lr, c_ov, c_last, c_zl;
    logic [3:0]  c_code;
    logic [4:0]  c_cnt;

    prio_scan_encoder #(.N(8), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_din), .load(a_ld), .load_ready(a_lr),
        .code(a_code), .out_valid(a_ov), .out_ready(a_ordy), .last(a_last),
        .pending_cnt(a_cnt), .zero_load(a_zl));

    prio_scan_encoder #(.N(8), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_din), .load(b_ld), .load_ready(b_lr),
        .code(b_code), .out_valid(b_ov), .out_ready(b_ordy), .last(b_last),
        .pending_cnt(b_cnt), .zero_load(b_zl));

    prio_scan_encoder #(.N(16), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .data_in(c_din), .load(c_ld), .load_ready(c_lr),
        .code(c_code), .out_valid(c_ov), .out_ready(c_ordy), .last(c_last),
        .pending_cnt(c_cnt), .zero_load(c_zl));

    // Observation vectors: {out_valid, code, last, pending_cnt, load_ready, zero_load}
    wire [10:0] a_obs = {a_ov, a_code, a_last, a_cnt, a_lr, a_zl};
    wire [10:0] b_obs = {b_ov, b_code, b_last, b_cnt, b_lr, b_zl};
    wire [12:0] c_obs = {c_ov, c_code, c_last, c_cnt, c_lr, c_zl};

    localparam logic [10:0] A_IDLE = {1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0};

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (a_obs !== A_IDLE) begin
            n_fail++; $display("FAIL reset_a: got %b expected %b", a_obs, A_IDLE);
        end
        n_checks++;
        if (c_obs !== {1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL reset_c: got %b expected %b", c_obs, {1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        a_din = 8'b1000_0000; a_ld = 1; a_ordy = 1;
        step();
        a_ld = 0;
        n_checks++;
        if (a_obs !== {1'b1, 3'd7, 1'b1, 4'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL single_code7: got %b expected %b", a_obs, {1'b1, 3'd7, 1'b1, 4'd1, 1'b0, 1'b0});
        end
        step();
        n_checks++;
        if (a_obs !== A_IDLE) begin
            n_fail++; $display("FAIL single_idle: got %b expected %b", a_obs, A_IDLE);
        end
    endtask

    task automatic test_two_bits();
        a_din = 8'b0110_0000; a_ld = 1; a_ordy = 1;
        step();
        a_ld = 0;
        n_checks++;
        if (a_obs !== {1'b1, 3'd6, 1'b0, 4'd2, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL two_code6: got %b expected %b", a_obs, {1'b1, 3'd6, 1'b0, 4'd2, 1'b0, 1'b0});
        end
        step();
        n_checks++;
        if (a_obs !== {1'b1, 3'd5, 1'b1, 4'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL two_code5: got %b expected %b", a_obs, {1'b1, 3'd5, 1'b1, 4'd1, 1'b0, 1'b0});
        end
        step();
        n_checks++;
        if (a_obs !== A_IDLE) begin
            n_fail++; $display("FAIL two_idle: got %b expected %b", a_obs, A_IDLE);
        end
    endtask

    task automatic test_lsb_first();
        logic [2:0] exp_code [3];
        exp_code[0] = 3'd0; exp_code[1] = 3'd4; exp_code[2] = 3'd7;
        b_din = 8'b1001_0001; b_ld = 1; b_ordy = 1;
        step();
        b_ld = 0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (b_obs !== {1'b1, exp_code[k], (k == 2), 4'(3 - k), 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL lsb_step%0d: got %b expected %b", k, b_obs,
                                   {1'b1, exp_code[k], (k == 2), 4'(3 - k), 1'b0, 1'b0});
            end
            step();
        end
        n_checks++;
        if (b_obs !== A_IDLE) begin
            n_fail++; $display("FAIL lsb_idle: got %b expected %b", b_obs, A_IDLE);
        end
    endtask

    task automatic test_backpressure();
        a_din = 8'b0000_0011; a_ld = 1; a_ordy = 0;
        step();
        a_din = 8'hFF;                // load during stall must be ignored
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (a_obs !== {1'b1, 3'd1, 1'b0, 4'd2, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold%0d: got %b expected %b", k, a_obs, {1'b1, 3'd1, 1'b0, 4'd2, 1'b0, 1'b0});
            end
            step();
        end
        a_ld = 0;
        n_checks++;
        if (a_obs !== {1'b1, 3'd1, 1'b0, 4'd2, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL bp_hold3: got %b expected %b", a_obs, {1'b1, 3'd1, 1'b0, 4'd2, 1'b0, 1'b0});
        end
        a_ordy = 1;
        step();
        n_checks++;
        if (a_obs !== {1'b1, 3'd0, 1'b1, 4'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL bp_code0: got %b expected %b", a_obs, {1'b1, 3'd0, 1'b1, 4'd1, 1'b0, 1'b0});
        end
        step();
        n_checks++;
        if (a_obs !== A_IDLE) begin
            n_fail++; $display("FAIL bp_idle: got %b expected %b", a_obs, A_IDLE);
        end
    endtask

    task automatic test_zero_load();
        a_din = 8'h00; a_ld = 1; a_ordy = 1;
        step();
        n_checks++;
        if (a_obs !== {1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL zero_pulse1: got %b expected %b", a_obs, {1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1});
        end
        step();                        // second back-to-back zero load
        n_checks++;
        if (a_obs !== {1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL zero_pulse2: got %b expected %b", a_obs, {1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1});
        end
        a_din = 8'b0000_0001;
        step();
        a_ld = 0;
        n_checks++;
        if (a_obs !== {1'b1, 3'd0, 1'b1, 4'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL zero_then_one: got %b expected %b", a_obs, {1'b1, 3'd0, 1'b1, 4'd1, 1'b0, 1'b0});
        end
        step();
        n_checks++;
        if (a_obs !== A_IDLE) begin
            n_fail++; $display("FAIL zero_idle: got %b expected %b", a_obs, A_IDLE);
        end
    endtask

    task automatic test_midscan_reset();
        a_din = 8'hFF; a_ld = 1; a_ordy = 1;
        step();
        a_ld = 0;
        n_checks++;
        if (a_obs !== {1'b1, 3'd7, 1'b0, 4'd8, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL mid_code7: got %b expected %b", a_obs, {1'b1, 3'd7, 1'b0, 4'd8, 1'b0, 1'b0});
        end
        step();
        n_checks++;
        if (a_obs !== {1'b1, 3'd6, 1'b0, 4'd7, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL mid_code6: got %b expected %b", a_obs, {1'b1, 3'd6, 1'b0, 4'd7, 1'b0, 1'b0});
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_obs !== A_IDLE) begin
            n_fail++; $display("FAIL mid_async: got %b expected %b", a_obs, A_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (a_obs !== A_IDLE) begin
                n_fail++; $display("FAIL mid_after%0d: got %b expected %b", k, a_obs, A_IDLE);
            end
        end
    endtask

    task automatic test_n16();
        c_din = 16'h8001; c_ld = 1; c_ordy = 0;
        step();
        c_ld = 0;
        n_checks++;
        if (c_obs !== {1'b1, 4'd15, 1'b0, 5'd2, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL n16_code15: got %b expected %b", c_obs, {1'b1, 4'd15, 1'b0, 5'd2, 1'b0, 1'b0});
        end
        c_ordy = 1;
        step();
        n_checks++;
        if (c_obs !== {1'b1, 4'd0, 1'b1, 5'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL n16_code0: got %b expected %b", c_obs, {1'b1, 4'd0, 1'b1, 5'd1, 1'b0, 1'b0});
        end
        step();
        n_checks++;
        if (c_obs !== {1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL n16_idle: got %b expected %b", c_obs, {1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_bits();
        test_lsb_first();
        test_backpressure();
        test_zero_load();
        test_midscan_reset();
        test_n16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
